// File: rtl/gated_pulse_divider.sv
// Multi-channel gated clock divider: each channel pulses once every DIV cycles while
// inp1&inp2 is high, delayed through LAT output stages, with a saturating pulse count.
module gated_pulse_divider #(
    parameter int CH  = 1,
    parameter int DIV = 2,
    parameter int LAT = 0,
    parameter int PCW = 8
) (
    input  logic                iccad_clk,
    input  logic                iccad_rst,
    input  logic [CH-1:0]       inp1,
    input  logic [CH-1:0]       inp2,
    input  logic                sync,
    input  logic                clr,
    output logic [CH-1:0]       out,
    output logic [CH*PCW-1:0]   pcount
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CH-1:0]          w_en;
    logic [CH-1:0]          w_load;
    logic [CH-1:0]          r_q;
    logic [CH-1:0][CW-1:0]  r_cnt;
    logic [CH-1:0][PCW-1:0] r_pcount;

    assign w_en = inp1 & inp2;

    // w_load is the value q takes on the coming edge; pcount keys off the same term.
    always_comb begin
        w_load = '0;
        for (int c = 0; c < CH; c++) begin
            w_load[c] = ~sync & w_en[c] & (r_cnt[c] == '0);
        end
    end

    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            r_cnt <= '0;
            r_q   <= '0;
        end else begin
            r_q <= w_load;
            for (int c = 0; c < CH; c++) begin
                if (sync || !w_en[c]) begin
                    r_cnt[c] <= '0;
                end else begin
                    r_cnt[c] <= (r_cnt[c] == CNT_LAST) ? '0 : r_cnt[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            r_pcount <= '0;
        end else if (clr) begin
            r_pcount <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (w_load[c] && (r_pcount[c] != '1)) begin
                    r_pcount[c] <= r_pcount[c] + PCW'(1);
                end
            end
        end
    end

    assign pcount = r_pcount;

    if (LAT == 0) begin : g_direct
        assign out = r_q;
    end else begin : g_pipe
        logic [CH-1:0] r_pipe [LAT];

        always_ff @(posedge iccad_clk or posedge iccad_rst) begin
            if (iccad_rst) begin
                for (int i = 0; i < LAT; i++) begin
                    r_pipe[i] <= '0;
                end
            end else begin
                r_pipe[0] <= r_q;
                for (int i = 1; i < LAT; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign out = r_pipe[LAT-1];
    end

endmodule

// File: tb/tb_gated_pulse_divider.sv
// Self-checking bench: four differently parameterised instances checked every edge
// against a run-length reference model, plus table-driven and hand-written sequences.
module tb_gated_pulse_divider;

    logic       clk, rst, sync, clr;
    logic [3:0] a_in1, a_in2, a_out;
    logic [7:0] a_pc;
    logic [1:0] b_in1, b_in2, b_out;
    logic [15:0] b_pc;
    logic       c_in1, c_in2, c_out;
    logic [7:0] c_pc;
    logic       d_in1, d_in2, d_out;
    logic [7:0] d_pc;

    int n_chk = 0;
    int n_fail = 0;

    localparam int P_CH [4] = '{4, 2, 1, 1};
    localparam int P_DIV[4] = '{1, 3, 4, 2};
    localparam int P_LAT[4] = '{3, 2, 0, 0};
    localparam int P_PCW[4] = '{2, 8, 8, 8};

    gated_pulse_divider #(.CH(4), .DIV(1), .LAT(3), .PCW(2)) u_a (
        .iccad_clk(clk), .iccad_rst(rst), .inp1(a_in1), .inp2(a_in2),
        .sync(sync), .clr(clr), .out(a_out), .pcount(a_pc));
    gated_pulse_divider #(.CH(2), .DIV(3), .LAT(2), .PCW(8)) u_b (
        .iccad_clk(clk), .iccad_rst(rst), .inp1(b_in1), .inp2(b_in2),
        .sync(sync), .clr(clr), .out(b_out), .pcount(b_pc));
    gated_pulse_divider #(.CH(1), .DIV(4), .LAT(0), .PCW(8)) u_c (
        .iccad_clk(clk), .iccad_rst(rst), .inp1(c_in1), .inp2(c_in2),
        .sync(sync), .clr(clr), .out(c_out), .pcount(c_pc));
    gated_pulse_divider #(.CH(1), .DIV(2), .LAT(0), .PCW(8)) u_d (
        .iccad_clk(clk), .iccad_rst(rst), .inp1(d_in1), .inp2(d_in2),
        .sync(sync), .clr(clr), .out(d_out), .pcount(d_pc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a channel pulses on the n-th consecutive enabled edge when n%DIV==0.
    int run [4][4];
    int pc  [4][4];
    bit qh  [4][4][8];

    typedef struct {
        logic       en;
        logic       exp_d_out;
        int         exp_d_pc;
        logic [1:0] exp_b_out;
        int         exp_b_pc0;
    } vec_t;
    vec_t tbl [9];

    int c_exp_out[8] = '{1, 0, 0, 1, 0, 0, 0, 1};
    int c_exp_pc [8] = '{1, 1, 1, 2, 2, 2, 2, 3};
    int a_exp_pc [6] = '{1, 2, 3, 3, 3, 3};
    int a_exp_out[4] = '{0, 0, 0, 1};

    function automatic logic [3:0] en_of(int inst);
        case (inst)
            0: return a_in1 & a_in2;
            1: return {2'b00, b_in1 & b_in2};
            2: return {3'b000, c_in1 & c_in2};
            default: return {3'b000, d_in1 & d_in2};
        endcase
    endfunction

    function automatic int get_out(int inst, int ch);
        case (inst)
            0: return int'(a_out[ch]);
            1: return int'(b_out[ch]);
            2: return int'(c_out);
            default: return int'(d_out);
        endcase
    endfunction

    function automatic int get_pc(int inst, int ch);
        case (inst)
            0: return int'(a_pc[ch*2 +: 2]);
            1: return int'(b_pc[ch*8 +: 8]);
            2: return int'(c_pc);
            default: return int'(d_pc);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            for (int ch = 0; ch < 4; ch++) begin
                run[i][ch] = 0;
                pc[i][ch]  = 0;
                for (int k = 0; k < 8; k++) qh[i][ch][k] = 1'b0;
            end
    endtask

    task automatic model_edge(int inst);
        logic [3:0] en;
        bit p;
        en = en_of(inst);
        for (int ch = 0; ch < P_CH[inst]; ch++) begin
            for (int k = 7; k > 0; k--) qh[inst][ch][k] = qh[inst][ch][k-1];
            p = 1'b0;
            if (sync || !en[ch]) begin
                run[inst][ch] = 0;
            end else begin
                p = ((run[inst][ch] % P_DIV[inst]) == 0);
                run[inst][ch]++;
            end
            qh[inst][ch][0] = p;
            if (clr) pc[inst][ch] = 0;
            else if (p && pc[inst][ch] < (1 << P_PCW[inst]) - 1) pc[inst][ch]++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++)
            for (int ch = 0; ch < P_CH[i]; ch++) begin
                check($sformatf("model i%0d c%0d out", i, ch), get_out(i, ch),
                      int'(qh[i][ch][P_LAT[i]]));
                check($sformatf("model i%0d c%0d pcount", i, ch), get_pc(i, ch),
                      pc[i][ch]);
            end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < 4; i++) model_edge(i);
        #1;
        check_all();
    endtask

    task automatic zero_inputs();
        a_in1 = '0; a_in2 = '0; b_in1 = '0; b_in2 = '0;
        c_in1 = 0;  c_in2 = 0;  d_in1 = 0;  d_in2 = 0;
        sync = 0;   clr = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1, 2'b00, 1};
        tbl[1] = '{1'b1, 1'b0, 1, 2'b00, 1};
        tbl[2] = '{1'b1, 1'b1, 2, 2'b01, 1};
        tbl[3] = '{1'b1, 1'b0, 2, 2'b00, 2};
        tbl[4] = '{1'b1, 1'b1, 3, 2'b00, 2};
        tbl[5] = '{1'b1, 1'b0, 3, 2'b01, 2};
        tbl[6] = '{1'b1, 1'b1, 4, 2'b00, 3};
        tbl[7] = '{1'b1, 1'b0, 4, 2'b00, 3};
        tbl[8] = '{1'b1, 1'b1, 5, 2'b01, 3};

        zero_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        do_reset();

        // DIV=2 toggle on u_d and DIV=3/LAT=2 on u_b with channel 1 gated off
        for (int k = 0; k < 9; k++) begin
            d_in1 = tbl[k].en; d_in2 = tbl[k].en;
            b_in1 = {1'b1, tbl[k].en}; b_in2 = {1'b0, tbl[k].en};
            step();
            check($sformatf("tbl%0d d_out", k), int'(d_out), int'(tbl[k].exp_d_out));
            check($sformatf("tbl%0d d_pc", k), int'(d_pc), tbl[k].exp_d_pc);
            check($sformatf("tbl%0d b_out", k), int'(b_out), int'(tbl[k].exp_b_out));
            check($sformatf("tbl%0d b_pc0", k), int'(b_pc[7:0]), tbl[k].exp_b_pc0);
            check($sformatf("tbl%0d b_pc1", k), int'(b_pc[15:8]), 0);
        end

        // sync on the edge where u_c's phase is 2
        do_reset();
        c_in1 = 1; c_in2 = 1;
        for (int k = 0; k < 8; k++) begin
            sync = (k == 2);
            step();
            check($sformatf("sync%0d c_out", k), int'(c_out), c_exp_out[k]);
            check($sformatf("sync%0d c_pc", k), int'(c_pc), c_exp_pc[k]);
        end
        sync = 0;

        // pcount saturation at PCW=2, then clr against a simultaneous increment
        do_reset();
        a_in1 = 4'hF; a_in2 = 4'hF;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("sat%0d a_pc0", k), int'(a_pc[1:0]), a_exp_pc[k]);
        end
        clr = 1;
        step();
        check("clr a_pc", int'(a_pc), 0);
        clr = 0;
        step();
        check("post-clr a_pc0", int'(a_pc[1:0]), 1);

        // async reset mid-cycle with pulses in flight through LAT=3
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("async rst a_out", int'(a_out), 0);
        check("async rst a_pc", int'(a_pc), 0);
        check_all();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rst-release%0d a_out0", k), int'(a_out[0]), a_exp_out[k]);
        end

        // randomized traffic against the model on all instances
        do_reset();
        for (int k = 0; k < 300; k++) begin
            a_in1 = 4'($urandom); a_in2 = 4'($urandom);
            b_in1 = 2'($urandom); b_in2 = 2'($urandom);
            c_in1 = ($urandom_range(0, 3) != 0); c_in2 = ($urandom_range(0, 3) != 0);
            d_in1 = ($urandom_range(0, 3) != 0); d_in2 = ($urandom_range(0, 3) != 0);
            sync  = ($urandom_range(0, 19) == 0);
            clr   = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
